// File: rtl/keypad_entry_ctrl.sv
// Matrix keypad scanner: column drive, whole-frame debounce, single-key events,
// hex entry register with clear/backspace, and a retriggerable beep.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_entry_ctrl #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE     = 4,
  parameter int DIGITS       = 6,
  parameter int CLR_CODE     = 15,
  parameter int BS_CODE      = 14,
`ifdef KEYPAD_REPEAT_EN
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 8,
`endif
  parameter int BEEP_CYCLES  = 5000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROWS-1:0]              row,
  output logic [COLS-1:0]              col,
  output logic [$clog2(ROWS*COLS)-1:0] key_num,
  output logic                         key_valid,
  output logic [DIGITS*4-1:0]          data_out,
  output logic                         full,
  output logic                         beep
);

  localparam int NK  = ROWS * COLS;
  localparam int KW  = $clog2(NK);
  localparam int DW  = DIGITS * 4;
  localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CIW = $clog2(COLS);
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int BW  = $clog2(BEEP_CYCLES + 1);

  logic [SW-1:0]  scan_cnt_reg;
  logic [CIW-1:0] col_idx_reg;
  logic [NK-1:0]  snap_reg, snap_next;
  logic [NK-1:0]  prev_reg;
  logic [DBW-1:0] stable_reg, stable_next;
  logic [NK-1:0]  deb_reg, deb_next;
  logic           key_valid_reg;
  logic [KW-1:0]  key_num_reg, code_next;
  logic [DW-1:0]  data_reg, data_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           full_reg;
  logic [BW-1:0]  beep_cnt_reg, beep_cnt_next;
  logic           beep_reg;

  logic           col_end, frame_end;
  logic           new_single, press_evt, key_evt;
  logic [31:0]    code_ext;
  logic [DW-1:0]  nib_ext;

  assign col_end   = (scan_cnt_reg == SW'(SCAN_DIV - 1));
  assign frame_end = col_end && (col_idx_reg == CIW'(COLS - 1));

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col[gi] = (col_idx_reg != CIW'(gi));
  end

  // Each key bit is refreshed only on the last cycle of its own column period.
  for (genvar gi = 0; gi < NK; gi++) begin : g_snap
    localparam int R = gi / COLS;
    localparam int C = gi % COLS;
    assign snap_next[gi] = (col_end && (col_idx_reg == CIW'(C))) ? ~row[R] : snap_reg[gi];
  end

  always_comb begin
    stable_next = stable_reg;
    deb_next    = deb_reg;
    if (frame_end) begin
      if (snap_next == prev_reg)
        stable_next = (stable_reg == DBW'(DEBOUNCE)) ? stable_reg : stable_reg + DBW'(1);
      else
        stable_next = DBW'(1);
      if (stable_next == DBW'(DEBOUNCE))
        deb_next = snap_next;
    end
  end

  always_comb begin
    code_next = '0;
    for (int i = 0; i < NK; i++)
      if (deb_next[i]) code_next = KW'(i);
  end

  // Only an idle-to-single-key transition counts as a press.
  assign new_single = (deb_next != '0) && ((deb_next & (deb_next - NK'(1))) == '0);
  assign press_evt  = frame_end && (deb_reg == '0) && new_single;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt_reg, rep_inc;
  logic          rep_armed_reg, rep_first_reg, rep_evt;

  assign rep_inc = rep_cnt_reg + RW'(1);
  assign rep_evt = frame_end && rep_armed_reg && (deb_next == deb_reg) &&
                   (rep_inc == (rep_first_reg ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));
  assign key_evt = press_evt | rep_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_reg   <= '0;
      rep_armed_reg <= 1'b0;
      rep_first_reg <= 1'b1;
    end else if (frame_end) begin
      if (deb_next != deb_reg) begin
        rep_armed_reg <= press_evt;
        rep_first_reg <= 1'b1;
        rep_cnt_reg   <= '0;
      end else if (rep_armed_reg) begin
        if (rep_evt) begin
          rep_cnt_reg   <= '0;
          rep_first_reg <= 1'b0;
        end else begin
          rep_cnt_reg <= rep_inc;
        end
      end
    end
  end
`else
  assign key_evt = press_evt;
`endif

  assign code_ext = 32'(key_num_reg);
  assign nib_ext  = DW'(code_ext[3:0]);

  always_comb begin
    data_next = data_reg;
    cnt_next  = cnt_reg;
    if (key_valid_reg) begin
      if (code_ext == 32'(CLR_CODE)) begin
        data_next = '0;
        cnt_next  = '0;
      end else if (code_ext == 32'(BS_CODE)) begin
        data_next = data_reg >> 4;
        if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
      end else if ((code_ext < 32'd16) && (cnt_reg != CW'(DIGITS))) begin
        data_next = (data_reg << 4) | nib_ext;
        cnt_next  = cnt_reg + CW'(1);
      end
    end
  end

  always_comb begin
    if (key_valid_reg)
      beep_cnt_next = BW'(BEEP_CYCLES);
    else if (beep_cnt_reg != '0)
      beep_cnt_next = beep_cnt_reg - BW'(1);
    else
      beep_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg  <= '0;
      col_idx_reg   <= '0;
      snap_reg      <= '0;
      prev_reg      <= '0;
      stable_reg    <= '0;
      deb_reg       <= '0;
      key_valid_reg <= 1'b0;
      key_num_reg   <= '0;
      data_reg      <= '0;
      cnt_reg       <= '0;
      full_reg      <= 1'b0;
      beep_cnt_reg  <= '0;
      beep_reg      <= 1'b0;
    end else begin
      if (col_end) begin
        scan_cnt_reg <= '0;
        col_idx_reg  <= (col_idx_reg == CIW'(COLS - 1)) ? '0 : col_idx_reg + CIW'(1);
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SW'(1);
      end
      snap_reg   <= snap_next;
      stable_reg <= stable_next;
      deb_reg    <= deb_next;
      if (frame_end) prev_reg <= snap_next;

      key_valid_reg <= key_evt;
      if (key_evt) key_num_reg <= code_next;

      data_reg     <= data_next;
      cnt_reg      <= cnt_next;
      full_reg     <= (cnt_next == CW'(DIGITS));
      beep_cnt_reg <= beep_cnt_next;
      beep_reg     <= (beep_cnt_next != '0);
    end
  end

  assign key_num   = key_num_reg;
  assign key_valid = key_valid_reg;
  assign data_out  = data_reg;
  assign full      = full_reg;
  assign beep      = beep_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: a key-matrix model drives row, expected
// events are queued at stimulus time and matched when key_valid fires.
module tb_keypad_entry_ctrl;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2, DIGITS = 3, BEEP_CYCLES = 10;
  localparam int FRAME = COLS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_num;
  logic        key_valid;
  logic [11:0] data_out;
  logic        full;
  logic        beep;
  logic [15:0] pressed = '0;

  typedef struct {
    int          code;
    logic [11:0] data;
    logic        full;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         model_data = 0;
  int         model_cnt = 0;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         kv_seen = 0;
  int         kv0;
  int         n_beep;
  logic [3:0] exp_col;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .DIGITS(DIGITS), .CLR_CODE(15), .BS_CODE(14), .BEEP_CYCLES(BEEP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_num(key_num),
    .key_valid(key_valid), .data_out(data_out), .full(full), .beep(beep)
  );

  // Closed key pulls its row low while its column is driven.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_key(input int code);
    exp_t e;
    if (code == 15) begin
      model_data = 0;
      model_cnt  = 0;
    end else if (code == 14) begin
      model_data = model_data >> 4;
      if (model_cnt > 0) model_cnt--;
    end else if (model_cnt < DIGITS) begin
      model_data = ((model_data << 4) | code) & 'hfff;
      model_cnt++;
    end
    e.code = code;
    e.data = 12'(model_data);
    e.full = (model_cnt == DIGITS);
    sb_q.push_back(e);
  endtask

  task automatic tap(input int code);
    expect_key(code);
    pressed[code] = 1'b1;
    repeat (4*FRAME) @(negedge clk);
    pressed[code] = 1'b0;
    repeat (4*FRAME) @(negedge clk);
  endtask

  task automatic wait_kv(input string tag, input int limit);
    int n;
    n = 0;
    while (!key_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_kv_seen"}, 32'(n < limit), 1);
  endtask

  // Monitor: pop the scoreboard on each event, then check the entry one cycle later.
  always begin
    @(negedge clk);
    if (rst_n && key_valid) begin
      kv_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_key_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("key_num", key_num, mon_e.code);
        @(negedge clk);
        $display("[TB] key %0d -> data_out 0x%03h full %0d beep %0d", mon_e.code, data_out, full, beep);
        if (rst_n) begin
          check("data_out", data_out, mon_e.data);
          check("full", full, mon_e.full);
          check("beep_on", beep, 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and column walk
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key_num", key_num, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_full", full, 0);
    check("rst_beep", beep, 0);
    rst_n = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_col = ~(4'b0001 << (j / 4));
      check("col_walk", col, exp_col);
      @(negedge clk);
    end
    repeat (3*FRAME) @(negedge clk);
    check("idle_data", data_out, 0);
    check("idle_beep", beep, 0);
    check("idle_no_ev", kv_seen, 0);

    // r1c2 press, beep length
    expect_key(6);
    pressed[6] = 1'b1;
    wait_kv("t2", 5*FRAME);
    check("t2_beep_pre", beep, 0);
    n_beep = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (beep) n_beep++;
    end
    check("t2_beep_len", n_beep, BEEP_CYCLES);
    check("t2_data", data_out, 12'h006);
    pressed[6] = 1'b0;
    repeat (4*FRAME) @(negedge clk);

    // Entry sequence with overflow, backspace and clear
    tap(15);
    tap(1);
    tap(2);
    tap(3);
    check("t3_data_123", data_out, 12'h123);
    check("t3_full", full, 1);
    tap(4);
    check("t3_overflow", data_out, 12'h123);
    tap(14);
    check("t3_bs_data", data_out, 12'h012);
    check("t3_bs_full", full, 0);
    tap(15);
    check("t3_clr", data_out, 12'h000);

    // Bounce: on/off/on one frame each, then stable
    kv0 = kv_seen;
    pressed[9] = 1'b1;
    repeat (FRAME) @(negedge clk);
    pressed[9] = 1'b0;
    repeat (FRAME) @(negedge clk);
    pressed[9] = 1'b1;
    repeat (FRAME) @(negedge clk);
    check("t4_no_ev_bounce", kv_seen - kv0, 0);
    expect_key(9);
    repeat (4*FRAME) @(negedge clk);
    pressed[9] = 1'b0;
    repeat (4*FRAME) @(negedge clk);
    check("t4_one_ev", kv_seen - kv0, 1);

    // Two keys, partial release, then fresh press
    kv0 = kv_seen;
    pressed[0]  = 1'b1;
    pressed[15] = 1'b1;
    repeat (3*FRAME) @(negedge clk);
    pressed[15] = 1'b0;
    repeat (3*FRAME) @(negedge clk);
    pressed[0] = 1'b0;
    repeat (4*FRAME) @(negedge clk);
    check("t5_multi_no_ev", kv_seen - kv0, 0);
    tap(0);
    check("t5_fresh_ev", kv_seen - kv0, 1);

    // Reset mid-beep with a key held
    expect_key(5);
    pressed[5] = 1'b1;
    wait_kv("t6", 5*FRAME);
    repeat (5) @(negedge clk);
    check("t6_beep_mid", beep, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_beep", beep, 0);
    check("t6_rst_data", data_out, 0);
    check("t6_rst_full", full, 0);
    check("t6_rst_key_num", key_num, 0);
    check("t6_rst_col", col, 4'b1110);
    model_data = 0;
    model_cnt  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    kv0 = kv_seen;
    expect_key(5);
    repeat (6*FRAME) @(negedge clk);
    pressed[5] = 1'b0;
    repeat (4*FRAME) @(negedge clk);
    check("t6_refire_once", kv_seen - kv0, 1);
    check("t6_data", data_out, 12'h005);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
